// File: rtl/memory_arbiter.sv
// Responder side of the cache<->memory protocol: one single-ported RAM shared by dcache and icache,
// dcache has fixed priority. Optional serve-state timeout abort via `ARB_TIMEOUT_EN.
module memory_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              arb_err
);

  typedef enum logic [1:0] {IDLE, DSERVE, ISERVE} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  state_t state, state_nxt;
  logic   hit;
  logic   tmo;

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  logic [CNT_W-1:0] cnt;

  // Counts busy serve cycles; any exit from a serve state goes through IDLE, which clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)              cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  assign tmo = (cnt == CNT_LAST) && !hit;
`else
  assign tmo = 1'b0;
`endif

  assign hit = (ramstate == RAM_ACCESS) || (ramstate == RAM_ERROR);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    dwait     = 1'b1;
    iwait     = 1'b1;
    dload     = '0;
    iload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    arb_err   = 1'b0;
    case (state)
      IDLE: begin
        if (dREN || dWEN) state_nxt = DSERVE;
        else if (iREN)    state_nxt = ISERVE;
      end
      DSERVE: begin
        if (!(dREN || dWEN)) begin
          state_nxt = IDLE;
        end else if (tmo) begin
          dwait     = 1'b0;
          dload     = DATA_W'(32'hDEAD_BEEF);
          arb_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN && !dWEN;
          if (hit) begin
            dwait     = 1'b0;
            dload     = ramload;
            arb_err   = (ramstate == RAM_ERROR);
            state_nxt = IDLE;
          end
        end
      end
      ISERVE: begin
        if (!iREN) begin
          state_nxt = IDLE;
        end else if (tmo) begin
          iwait     = 1'b0;
          iload     = DATA_W'(32'hDEAD_BEEF);
          arb_err   = 1'b1;
          state_nxt = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          if (hit) begin
            iwait     = 1'b0;
            iload     = ramload;
            arb_err   = (ramstate == RAM_ERROR);
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized bench for memory_arbiter against a transaction-owner reference model.
module tb_memory_arbiter;

  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_ON = 1'b1;
`else
  localparam bit TO_ON = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        dREN = 0, dWEN = 0, iREN = 0;
  logic [31:0] daddr = 0, dstore = 0, iaddr = 0, ramload = 0;
  logic [1:0]  ramstate = 0;
  logic        dwait, iwait, ramREN, ramWEN, arb_err;
  logic [31:0] dload, iload, ramaddr, ramstore;

  int n_vec = 0, n_err = 0;
  int owner = 0;      // 0 = nobody, 1 = dcache, 2 = icache
  int busy_cnt = 0;   // busy cycles spent serving the current owner
  logic last_dw = 1, last_iw = 1;

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .arb_err(arb_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cycle();
    logic e_dw, e_iw, e_rr, e_rw, e_err;
    logic [31:0] e_dl, e_il, e_ra, e_rs, v;
    int nxt;
    bit hit, req, fin;
    #1;
    e_dw = 1; e_iw = 1; e_rr = 0; e_rw = 0; e_err = 0;
    e_dl = 0; e_il = 0; e_ra = 0; e_rs = 0; v = 0; fin = 0;
    nxt = owner;
    hit = (ramstate == 2'd2) || (ramstate == 2'd3);
    if (owner == 0) begin
      if (dREN || dWEN) nxt = 1;
      else if (iREN)    nxt = 2;
      busy_cnt = 0;
    end else begin
      req = (owner == 1) ? (dREN || dWEN) : iREN;
      if (!req) begin
        nxt = 0;
      end else if (TO_ON && !hit && busy_cnt == TO - 1) begin
        fin = 1; v = 32'hDEAD_BEEF; e_err = 1; nxt = 0;
      end else begin
        if (owner == 1) begin
          e_ra = daddr; e_rs = dstore; e_rw = dWEN; e_rr = dREN && !dWEN;
        end else begin
          e_ra = iaddr; e_rr = 1;
        end
        if (hit) begin
          fin = 1; v = ramload; e_err = (ramstate == 2'd3); nxt = 0;
        end else begin
          busy_cnt++;
        end
      end
      if (fin && owner == 1) begin e_dw = 0; e_dl = v; end
      if (fin && owner == 2) begin e_iw = 0; e_il = v; end
    end
    chk("dwait", dwait, e_dw);
    chk("iwait", iwait, e_iw);
    chk("dload", dload, e_dl);
    chk("iload", iload, e_il);
    chk("ramREN", ramREN, e_rr);
    chk("ramWEN", ramWEN, e_rw);
    chk("ramaddr", ramaddr, e_ra);
    chk("ramstore", ramstore, e_rs);
    chk("arb_err", arb_err, e_err);
    owner = nxt;
    last_dw = e_dw;
    last_iw = e_iw;
  endtask

  task automatic cyc(input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] ds,
                     input logic ir, input logic [31:0] ia, input logic [1:0] rs, input logic [31:0] rl);
    @(negedge CLK);
    dREN = dr; dWEN = dw; daddr = da; dstore = ds;
    iREN = ir; iaddr = ia; ramstate = rs; ramload = rl;
    check_cycle();
  endtask

  logic        d_act = 0, d_r = 0, d_w = 0, i_act = 0;
  logic [31:0] d_a = 0, d_s = 0, i_a = 0;
  logic [1:0]  rs_r;
  int k;

  initial begin
    // Reset state
    #3;
    chk("rst_dwait", dwait, 1'b1);
    chk("rst_ramREN", ramREN, 1'b0);
    chk("rst_ramaddr", ramaddr, 32'h0);
    @(negedge CLK); nRST = 1'b1;

    // Read with ACCESS on the third cycle
    cyc(1, 0, 32'h100, 0, 0, 0, 2'd1, 32'h0);
    cyc(1, 0, 32'h100, 0, 0, 0, 2'd1, 32'h0);
    cyc(1, 0, 32'h100, 0, 0, 0, 2'd2, 32'hCAFE_0001);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    // Simultaneous dcache/icache requests: dcache first
    cyc(1, 0, 32'h300, 0, 1, 32'h400, 2'd1, 32'h0);
    cyc(1, 0, 32'h300, 0, 1, 32'h400, 2'd2, 32'h11);
    cyc(0, 0, 0, 0, 1, 32'h400, 2'd1, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h400, 2'd2, 32'h22);
    // Write, then read+write treated as write
    cyc(0, 1, 32'h200, 32'h1234_5678, 0, 0, 2'd1, 32'h0);
    cyc(0, 1, 32'h200, 32'h1234_5678, 0, 0, 2'd1, 32'h0);
    cyc(0, 1, 32'h200, 32'h1234_5678, 0, 0, 2'd2, 32'h0);
    cyc(1, 1, 32'h204, 32'hA5A5_5A5A, 0, 0, 2'd1, 32'h0);
    cyc(1, 1, 32'h204, 32'hA5A5_5A5A, 0, 0, 2'd2, 32'h0);
    // ERROR during icache serve
    cyc(0, 0, 0, 0, 1, 32'h500, 2'd1, 32'h0);
    cyc(0, 0, 0, 0, 1, 32'h500, 2'd3, 32'h33);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    // Reset mid-DSERVE
    cyc(1, 0, 32'h600, 0, 0, 0, 2'd1, 32'h0);
    cyc(1, 0, 32'h600, 0, 0, 0, 2'd1, 32'h0);
    #1 nRST = 1'b0;
    #1;
    chk("midrst_ramREN", ramREN, 1'b0);
    chk("midrst_ramaddr", ramaddr, 32'h0);
    chk("midrst_dwait", dwait, 1'b1);
    owner = 0;
    @(posedge CLK); #2 nRST = 1'b1;
    cyc(1, 0, 32'h600, 0, 0, 0, 2'd1, 32'h0);
    cyc(1, 0, 32'h600, 0, 0, 0, 2'd2, 32'h44);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);
    // Stuck BUSY: times out on the 8th serve cycle when enabled
    for (int c = 0; c < TO + 1; c++) cyc(1, 0, 32'h700, 0, 0, 0, 2'd1, 32'h0);
    cyc(0, 0, 0, 0, 0, 0, 2'd0, 32'h0);

    // Randomized traffic honouring the hold-until-complete protocol
    for (int c = 0; c < 3000; c++) begin
      if (!d_act && $urandom_range(0, 2) == 0) begin
        d_act = 1; k = $urandom_range(0, 2);
        d_r = (k != 1); d_w = (k != 0); d_a = $urandom; d_s = $urandom;
      end
      if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; i_a = $urandom;
      end
      k = $urandom_range(0, 15);
      rs_r = (k == 0) ? 2'd3 : (k < 5) ? 2'd2 : (k < 7) ? 2'd0 : 2'd1;
      cyc(d_act && d_r, d_act && d_w, d_a, d_s, i_act, i_a, rs_r, $urandom);
      if (!last_dw) d_act = 0;
      else if (d_act && $urandom_range(0, 39) == 0) d_act = 0;
      if (!last_iw) i_act = 0;
      else if (i_act && $urandom_range(0, 39) == 0) i_act = 0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
